reg_bank_ovr: RTL and testbench
===============================

Name: reg_bank_ovr

Overview:
Parametrised register bank with per-entry override (force/release) and a value-membership query. It is the synthesizable successor to the team's assign/deassign and "inside"-on-collection experiments. Each register holds a written base value. A force overlays that base value until release, and RELEASE_MODE selects what the register holds after release: deassign-style (keep the forced value) or release-style (revert to the base). It sits beside CSR blocks as a debug/override register file with a membership lookup.

Parameters:
NUM_REGS, 4, number of registers (>=2)
DATA_W, 32, register width in bits
RESET_VAL, 0, reset value loaded into every base register (DATA_W bits)
RELEASE_MODE, 0, 0 = deassign semantics (forced value persists after release); 1 = release semantics (revert to base)
AW (localparam), $clog2(NUM_REGS), address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write base register
wr_addr  in  AW  write address
wr_data  in  DATA_W  write data
frc_en  in  1  force register
frc_addr  in  AW  force address
frc_data  in  DATA_W  force value
rel_en  in  1  release register
rel_addr  in  AW  release address
rd_en  in  1  read request
rd_addr  in  AW  read address
rd_valid  out  1  read data valid, 1 cycle after rd_en
rd_data  out  DATA_W  effective value read
rd_forced  out  1  entry was forced when sampled
qry_valid  in  1  membership query request
qry_data  in  DATA_W  value to search for
qry_done  out  1  query result valid, 1 cycle after qry_valid
qry_hit  out  1  some effective value equals qry_data
qry_idx  out  AW  lowest matching index (0 if no hit)
eff_flat  out  NUM_REGS*DATA_W  all effective values; entry i at [i*DATA_W +: DATA_W]
forced_mask  out  NUM_REGS  per-entry force flag

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- State per entry i: base b[i], force flag f[i], force value fv[i].
- Effective value e[i] = f[i] ? fv[i] : b[i]. eff_flat and forced_mask are combinational from registered state.
- Reset (async assert): b[i]=RESET_VAL, f[i]=0, fv[i]=0. Outputs rd_valid=0, rd_data=0, rd_forced=0, qry_done=0, qry_hit=0, qry_idx=0. Reset mid-operation drops any pending read/query response.
- Write: wr_en updates b[wr_addr] at the next edge. It is accepted while forced, but e[] is unchanged while forced.
- Force: frc_en sets f[frc_addr]=1 and fv[frc_addr]=frc_data. Re-forcing a forced entry updates fv.
- Release: rel_en clears f[rel_addr].
  - RELEASE_MODE=0: b[rel_addr] <= fv[rel_addr], so e[] holds the forced value until the next write.
  - RELEASE_MODE=1: b is untouched, so e[] reverts to the last written base, including writes made during the force.
- Same-address collisions in one cycle:
  - force+release: force wins (f=1, fv=frc_data).
  - release+write, mode 0: write wins (b=wr_data).
  - force+write: both apply (b=wr_data, f=1).
  - release on an unforced entry: no-op in both modes.
- Out-of-range addresses (>=NUM_REGS, when NUM_REGS is not a power of 2):
  - writes, forces and releases are ignored;
  - a read returns rd_data=0, rd_forced=0 and rd_valid=1.
- Read latency 1: rd_data/rd_forced reflect e[]/f[] before any same-cycle update. rd_valid is a 1-cycle pulse per rd_en; back-to-back reads are allowed every cycle.
- Query latency 1: compare qry_data against all e[] as of the sampling cycle (pre-update). qry_hit=OR of matches; qry_idx=lowest matching index. qry_done pulses 1 cycle; qry_hit/qry_idx hold until the next query.

Test Plan:
- Reset: rst_n low, then high -> every eff_flat entry = RESET_VAL, forced_mask=0, rd_valid=0, qry_done=0. A read of addr 2 returns RESET_VAL with rd_forced=0 one cycle later.
- Mode 0 force/release (NUM_REGS=4, DATA_W=32): write 0x11 to reg1, force 0xAA, write 0x22, release -> e[1]=0xAA after the force. After the write, e[1] is still 0xAA. After release, e[1]=0xAA and b=0xAA. A subsequent write of 0x33 gives e[1]=0x33.
- Mode 1, same sequence -> after release e[1]=0x22.
- Collisions on reg3 (forced at 0x5): force 0x7 + release in one cycle -> forced_mask[3]=1, e[3]=0x7. In mode 0, release + write 0x9 in one cycle -> e[3]=0x9, forced_mask[3]=0.
- Read timing: rd_en with rd_addr=0 in the same cycle as a write of 0xBEEF to reg0 -> next cycle rd_valid=1 with the old value. A read the following cycle returns 0xBEEF.
- Query: regs = {0x1, 0x5, 0x5, 0x9}, reg2 forced to 0xC.
  - qry_data=0x5 -> qry_done=1, qry_hit=1, qry_idx=1.
  - qry_data=0xC -> hit, idx=2.
  - qry_data=0x4 -> qry_hit=0, qry_idx=0.

Source files
------------

// File: rtl/reg_bank_ovr.sv
// Register bank with per-entry force/release override and a membership query.
// Each entry has a written base value; a force overlays it until release, and
// RELEASE_MODE picks whether the forced value persists (0) or the base returns (1).
module reg_bank_ovr #(
   parameter int unsigned          NUM_REGS     = 4,
   parameter int unsigned          DATA_W       = 32,
   parameter logic [DATA_W-1:0]    RESET_VAL    = '0,
   parameter int unsigned          RELEASE_MODE = 0,
   localparam int unsigned         AW           = $clog2(NUM_REGS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [AW-1:0]                wr_addr,
   input  logic [DATA_W-1:0]            wr_data,
   input  logic                         frc_en,
   input  logic [AW-1:0]                frc_addr,
   input  logic [DATA_W-1:0]            frc_data,
   input  logic                         rel_en,
   input  logic [AW-1:0]                rel_addr,
   input  logic                         rd_en,
   input  logic [AW-1:0]                rd_addr,
   output logic                         rd_valid,
   output logic [DATA_W-1:0]            rd_data,
   output logic                         rd_forced,
   input  logic                         qry_valid,
   input  logic [DATA_W-1:0]            qry_data,
   output logic                         qry_done,
   output logic                         qry_hit,
   output logic [AW-1:0]                qry_idx,
   output logic [NUM_REGS*DATA_W-1:0]   eff_flat,
   output logic [NUM_REGS-1:0]          forced_mask
);

   logic [DATA_W-1:0]   base_q [NUM_REGS];
   logic [DATA_W-1:0]   base_d [NUM_REGS];
   logic [DATA_W-1:0]   fv_q   [NUM_REGS];
   logic [DATA_W-1:0]   fv_d   [NUM_REGS];
   logic [NUM_REGS-1:0] frc_q, frc_d;
   logic [DATA_W-1:0]   eff    [NUM_REGS];

   logic                rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                rd_forced_q, rd_forced_d;
   logic                qry_done_q, qry_done_d;
   logic                qry_hit_q, qry_hit_d;
   logic [AW-1:0]       qry_idx_q, qry_idx_d;

   logic [DATA_W-1:0]   rd_sel_data;
   logic                rd_sel_frc;
   logic                q_hit;
   logic [AW-1:0]       q_idx;

   // Effective values and flattened views
   always_comb begin
      eff_flat = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         eff[i] = frc_q[i] ? fv_q[i] : base_q[i];
         eff_flat[i*DATA_W +: DATA_W] = eff[i];
      end
   end

   assign forced_mask = frc_q;

   // Read mux and lowest-index query match; out-of-range reads fall through to 0
   always_comb begin
      rd_sel_data = '0;
      rd_sel_frc  = 1'b0;
      q_hit       = 1'b0;
      q_idx       = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_addr == AW'(i)) begin
            rd_sel_data = eff[i];
            rd_sel_frc  = frc_q[i];
         end
      end
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         if (eff[i] == qry_data) begin
            q_hit = 1'b1;
            q_idx = AW'(i);
         end
      end
   end

   // Next state: release first, then write (wins over release), then force (wins over release)
   always_comb begin
      frc_d = frc_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         base_d[i] = base_q[i];
         fv_d[i]   = fv_q[i];
         if (rel_en && (rel_addr == AW'(i)) && frc_q[i] &&
             !(frc_en && (frc_addr == AW'(i)))) begin
            frc_d[i] = 1'b0;
            if (RELEASE_MODE == 0) base_d[i] = fv_q[i];
         end
         if (wr_en && (wr_addr == AW'(i))) base_d[i] = wr_data;
         if (frc_en && (frc_addr == AW'(i))) begin
            frc_d[i] = 1'b1;
            fv_d[i]  = frc_data;
         end
      end
      rd_valid_d  = rd_en;
      rd_data_d   = rd_en ? rd_sel_data : rd_data_q;
      rd_forced_d = rd_en ? rd_sel_frc  : rd_forced_q;
      qry_done_d  = qry_valid;
      qry_hit_d   = qry_valid ? q_hit : qry_hit_q;
      qry_idx_d   = qry_valid ? q_idx : qry_idx_q;
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            base_q[i] <= RESET_VAL;
            fv_q[i]   <= '0;
         end
         frc_q       <= '0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         rd_forced_q <= 1'b0;
         qry_done_q  <= 1'b0;
         qry_hit_q   <= 1'b0;
         qry_idx_q   <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            base_q[i] <= base_d[i];
            fv_q[i]   <= fv_d[i];
         end
         frc_q       <= frc_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         rd_forced_q <= rd_forced_d;
         qry_done_q  <= qry_done_d;
         qry_hit_q   <= qry_hit_d;
         qry_idx_q   <= qry_idx_d;
      end
   end

   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign rd_forced = rd_forced_q;
   assign qry_done  = qry_done_q;
   assign qry_hit   = qry_hit_q;
   assign qry_idx   = qry_idx_q;

endmodule

// File: tb/tb_reg_bank_ovr.sv
// Directed bench: mode-0 and mode-1 banks of 4, plus a 3-entry bank for out-of-range reads.
module tb_reg_bank_ovr;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en, frc_en, rel_en, rd_en, qry_valid;
   logic [1:0]  wr_addr, frc_addr, rel_addr, rd_addr;
   logic [31:0] wr_data, frc_data, qry_data;

   logic        rv0, rf0, qd0, qh0;
   logic [31:0] rd0;
   logic [1:0]  qi0;
   logic [127:0] ef0;
   logic [3:0]  fm0;

   logic        rv1, rf1, qd1, qh1;
   logic [31:0] rd1;
   logic [1:0]  qi1;
   logic [127:0] ef1;
   logic [3:0]  fm1;

   logic        rv2, rf2, qd2, qh2;
   logic [31:0] rd2;
   logic [1:0]  qi2;
   logic [95:0] ef2;
   logic [2:0]  fm2;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   reg_bank_ovr #(.NUM_REGS(4), .DATA_W(32), .RESET_VAL(32'h0), .RELEASE_MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .frc_en(frc_en), .frc_addr(frc_addr), .frc_data(frc_data),
      .rel_en(rel_en), .rel_addr(rel_addr),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_valid(rv0), .rd_data(rd0), .rd_forced(rf0),
      .qry_valid(qry_valid), .qry_data(qry_data),
      .qry_done(qd0), .qry_hit(qh0), .qry_idx(qi0),
      .eff_flat(ef0), .forced_mask(fm0));

   reg_bank_ovr #(.NUM_REGS(4), .DATA_W(32), .RESET_VAL(32'h0), .RELEASE_MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .frc_en(frc_en), .frc_addr(frc_addr), .frc_data(frc_data),
      .rel_en(rel_en), .rel_addr(rel_addr),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_valid(rv1), .rd_data(rd1), .rd_forced(rf1),
      .qry_valid(qry_valid), .qry_data(qry_data),
      .qry_done(qd1), .qry_hit(qh1), .qry_idx(qi1),
      .eff_flat(ef1), .forced_mask(fm1));

   reg_bank_ovr #(.NUM_REGS(3), .DATA_W(32), .RESET_VAL(32'h5A), .RELEASE_MODE(0)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .frc_en(frc_en), .frc_addr(frc_addr), .frc_data(frc_data),
      .rel_en(rel_en), .rel_addr(rel_addr),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_valid(rv2), .rd_data(rd2), .rd_forced(rf2),
      .qry_valid(qry_valid), .qry_data(qry_data),
      .qry_done(qd2), .qry_hit(qh2), .qry_idx(qi2),
      .eff_flat(ef2), .forced_mask(fm2));

   // Drop all request strobes
   task automatic idle();
      wr_en = 1'b0; frc_en = 1'b0; rel_en = 1'b0; rd_en = 1'b0; qry_valid = 1'b0;
   endtask

   // Advance one edge; outputs are sampled 1 ns after it
   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic test_reset();
      idle();
      wr_addr = '0; frc_addr = '0; rel_addr = '0; rd_addr = '0;
      wr_data = '0; frc_data = '0; qry_data = '0;
      rst_n = 1'b0;
      #23;
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (ef0[i*32 +: 32] !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_eff0[%0d]: got %h want %h", i, ef0[i*32 +: 32], 32'h0);
         end
      end
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (ef2[i*32 +: 32] !== 32'h5A) begin
            miscompares++;
            $display("FAIL reset_eff2[%0d]: got %h want %h", i, ef2[i*32 +: 32], 32'h5A);
         end
      end
      vectors++;
      if ({fm0, rv0, qd0, qh0, qi0} !== 9'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got mask=%b rv=%b qd=%b qh=%b qi=%0d want all 0",
                  fm0, rv0, qd0, qh0, qi0);
      end
      @(negedge clk);
      rd_en = 1'b1; rd_addr = 2'd2;
      tick();
      vectors++;
      if ({rv0, rf0, rd0} !== {1'b1, 1'b0, 32'h0}) begin
         miscompares++;
         $display("FAIL reset_read0: got v=%b f=%b d=%h want v=1 f=0 d=0", rv0, rf0, rd0);
      end
      vectors++;
      if ({rv2, rf2, rd2} !== {1'b1, 1'b0, 32'h5A}) begin
         miscompares++;
         $display("FAIL reset_read2: got v=%b f=%b d=%h want v=1 f=0 d=5a", rv2, rf2, rd2);
      end
   endtask

   task automatic test_force_release();
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'h11;
      tick();
      frc_en = 1'b1; frc_addr = 2'd1; frc_data = 32'hAA;
      tick();
      vectors++;
      if ({ef0[63:32], ef1[63:32], fm0[1], fm1[1]} !== {32'hAA, 32'hAA, 2'b11}) begin
         miscompares++;
         $display("FAIL force_apply: got e0=%h e1=%h m0=%b m1=%b want aa aa 1 1",
                  ef0[63:32], ef1[63:32], fm0[1], fm1[1]);
      end
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'h22;
      tick();
      vectors++;
      if ({ef0[63:32], ef1[63:32]} !== {32'hAA, 32'hAA}) begin
         miscompares++;
         $display("FAIL write_while_forced: got e0=%h e1=%h want aa aa", ef0[63:32], ef1[63:32]);
      end
      rel_en = 1'b1; rel_addr = 2'd1;
      tick();
      vectors++;
      if ({ef0[63:32], fm0[1]} !== {32'hAA, 1'b0}) begin
         miscompares++;
         $display("FAIL release_mode0: got e=%h m=%b want aa 0", ef0[63:32], fm0[1]);
      end
      vectors++;
      if ({ef1[63:32], fm1[1]} !== {32'h22, 1'b0}) begin
         miscompares++;
         $display("FAIL release_mode1: got e=%h m=%b want 22 0", ef1[63:32], fm1[1]);
      end
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'h33;
      tick();
      vectors++;
      if ({ef0[63:32], ef1[63:32]} !== {32'h33, 32'h33}) begin
         miscompares++;
         $display("FAIL write_after_release: got e0=%h e1=%h want 33 33", ef0[63:32], ef1[63:32]);
      end
   endtask

   task automatic test_collisions();
      frc_en = 1'b1; frc_addr = 2'd3; frc_data = 32'h5;
      tick();
      frc_en = 1'b1; frc_addr = 2'd3; frc_data = 32'h7;
      rel_en = 1'b1; rel_addr = 2'd3;
      tick();
      vectors++;
      if ({ef0[127:96], fm0[3], ef1[127:96], fm1[3]} !== {32'h7, 1'b1, 32'h7, 1'b1}) begin
         miscompares++;
         $display("FAIL force_beats_release: got e0=%h m0=%b e1=%h m1=%b want 7 1 7 1",
                  ef0[127:96], fm0[3], ef1[127:96], fm1[3]);
      end
      rel_en = 1'b1; rel_addr = 2'd3;
      wr_en = 1'b1; wr_addr = 2'd3; wr_data = 32'h9;
      tick();
      vectors++;
      if ({ef0[127:96], fm0[3], ef1[127:96], fm1[3]} !== {32'h9, 1'b0, 32'h9, 1'b0}) begin
         miscompares++;
         $display("FAIL write_beats_release: got e0=%h m0=%b e1=%h m1=%b want 9 0 9 0",
                  ef0[127:96], fm0[3], ef1[127:96], fm1[3]);
      end
      frc_en = 1'b1; frc_addr = 2'd0; frc_data = 32'h1;
      wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'h2;
      tick();
      vectors++;
      if ({ef0[31:0], fm0[0], ef1[31:0], fm1[0]} !== {32'h1, 1'b1, 32'h1, 1'b1}) begin
         miscompares++;
         $display("FAIL force_and_write: got e0=%h m0=%b e1=%h m1=%b want 1 1 1 1",
                  ef0[31:0], fm0[0], ef1[31:0], fm1[0]);
      end
      rel_en = 1'b1; rel_addr = 2'd0;
      tick();
      vectors++;
      if ({ef0[31:0], ef1[31:0]} !== {32'h1, 32'h2}) begin
         miscompares++;
         $display("FAIL release_after_force_write: got e0=%h e1=%h want 1 2", ef0[31:0], ef1[31:0]);
      end
      rel_en = 1'b1; rel_addr = 2'd2;
      tick();
      vectors++;
      if ({ef0[95:64], fm0[2], ef1[95:64]} !== {32'h0, 1'b0, 32'h0}) begin
         miscompares++;
         $display("FAIL release_unforced: got e0=%h m0=%b e1=%h want 0 0 0",
                  ef0[95:64], fm0[2], ef1[95:64]);
      end
   endtask

   task automatic test_back_to_back();
      wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'hBEEF;
      rd_en = 1'b1; rd_addr = 2'd0;
      tick();
      vectors++;
      if ({rv0, rd0, rf0, rv1, rd1} !== {1'b1, 32'h1, 1'b0, 1'b1, 32'h2}) begin
         miscompares++;
         $display("FAIL read_pre_update: got v0=%b d0=%h f0=%b v1=%b d1=%h want 1 1 0 1 2",
                  rv0, rd0, rf0, rv1, rd1);
      end
      rd_en = 1'b1; rd_addr = 2'd0;
      tick();
      vectors++;
      if ({rv0, rd0, rv1, rd1} !== {1'b1, 32'hBEEF, 1'b1, 32'hBEEF}) begin
         miscompares++;
         $display("FAIL read_post_update: got v0=%b d0=%h v1=%b d1=%h want 1 beef 1 beef",
                  rv0, rd0, rv1, rd1);
      end
      tick();
      vectors++;
      if (rv0 !== 1'b0) begin
         miscompares++;
         $display("FAIL rd_valid_pulse: got %b want 0", rv0);
      end
   endtask

   task automatic test_out_of_range();
      frc_en = 1'b1; frc_addr = 2'd1; frc_data = 32'h66;
      tick();
      rd_en = 1'b1; rd_addr = 2'd3;
      tick();
      vectors++;
      if ({rv2, rd2, rf2} !== {1'b1, 32'h0, 1'b0}) begin
         miscompares++;
         $display("FAIL oor_read: got v=%b d=%h f=%b want 1 0 0", rv2, rd2, rf2);
      end
      rd_en = 1'b1; rd_addr = 2'd1;
      tick();
      vectors++;
      if ({rv0, rd0, rf0} !== {1'b1, 32'h66, 1'b1}) begin
         miscompares++;
         $display("FAIL read_forced: got v=%b d=%h f=%b want 1 66 1", rv0, rd0, rf0);
      end
      rel_en = 1'b1; rel_addr = 2'd1;
      tick();
   endtask

   task automatic test_query();
      wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'h1; tick();
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'h5; tick();
      wr_en = 1'b1; wr_addr = 2'd2; wr_data = 32'h5; tick();
      wr_en = 1'b1; wr_addr = 2'd3; wr_data = 32'h9; tick();
      frc_en = 1'b1; frc_addr = 2'd2; frc_data = 32'hC; tick();
      qry_valid = 1'b1; qry_data = 32'h5;
      tick();
      vectors++;
      if ({qd0, qh0, qi0} !== {1'b1, 1'b1, 2'd1}) begin
         miscompares++;
         $display("FAIL query_5: got done=%b hit=%b idx=%0d want 1 1 1", qd0, qh0, qi0);
      end
      qry_valid = 1'b1; qry_data = 32'hC;
      tick();
      vectors++;
      if ({qd0, qh0, qi0} !== {1'b1, 1'b1, 2'd2}) begin
         miscompares++;
         $display("FAIL query_c: got done=%b hit=%b idx=%0d want 1 1 2", qd0, qh0, qi0);
      end
      tick();
      vectors++;
      if ({qd0, qh0, qi0} !== {1'b0, 1'b1, 2'd2}) begin
         miscompares++;
         $display("FAIL query_hold: got done=%b hit=%b idx=%0d want 0 1 2", qd0, qh0, qi0);
      end
      qry_valid = 1'b1; qry_data = 32'h4;
      tick();
      vectors++;
      if ({qd0, qh0, qi0} !== {1'b1, 1'b0, 2'd0}) begin
         miscompares++;
         $display("FAIL query_miss: got done=%b hit=%b idx=%0d want 1 0 0", qd0, qh0, qi0);
      end
   endtask

   initial begin
      test_reset();
      test_force_release();
      test_collisions();
      test_back_to_back();
      test_out_of_range();
      test_query();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
